// File: rtl/memory_cycle.sv
// Memory stage of a 16-bit pipeline: X register, data-memory access FSM
// with wait/timeout counter, and the W (writeback) register.
module memory_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] aluout,
    input  logic [15:0] bout,
    input  logic [3:0]  rd,
    input  logic        regwrite,
    input  logic [3:0]  op,
    input  logic        pcwrite,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [15:0] new_mem_aluout,
    output logic [3:0]  mem_rd,
    output logic        mem_regwrite,
    output logic        mem_pcwrite,
    output logic [15:0] wb_data,
    output logic [3:0]  wb_rd,
    output logic        wb_regwrite,
    output logic        mem_err
);

    localparam logic [3:0] OpNop = 4'b0000;
    localparam logic [3:0] OpLw  = 4'b0100;
    localparam logic [3:0] OpSw  = 4'b0101;

    // Last wait-count value before the timeout edge; 255 ACCESS cycles total.
    localparam logic [7:0] CntLast = 8'd254;

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] load_q, load_d;
    logic        timeout_q, timeout_d;

    logic [15:0] x_aluout, x_bout;
    logic [3:0]  x_rd, x_op;
    logic        x_regwrite, x_pcwrite;

    logic [15:0] wb_data_d;
    logic [3:0]  wb_rd_d;
    logic        wb_regwrite_d, mem_err_d;

    logic in_start;
    logic x_is_mem;
    logic x_misaligned;
    logic err;

    assign stall        = (state_q == StAccess);
    assign in_start     = !stall && !flush && ((op == OpLw) || (op == OpSw)) && !aluout[0];
    assign x_is_mem     = (x_op == OpLw) || (x_op == OpSw);
    assign x_misaligned = x_is_mem && x_aluout[0];

    // X register: capture when not stalled; flush replaces the instruction with a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_aluout   <= '0;
            x_bout     <= '0;
            x_rd       <= '0;
            x_regwrite <= 1'b0;
            x_op       <= OpNop;
            x_pcwrite  <= 1'b0;
        end else if (!stall) begin
            if (flush) begin
                x_aluout   <= '0;
                x_bout     <= '0;
                x_rd       <= '0;
                x_regwrite <= 1'b0;
                x_op       <= OpNop;
                x_pcwrite  <= 1'b0;
            end else begin
                x_aluout   <= aluout;
                x_bout     <= bout;
                x_rd       <= rd;
                x_regwrite <= regwrite;
                x_op       <= op;
                x_pcwrite  <= pcwrite;
            end
        end
    end

    // FSM, wait counter, load data and timeout flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            load_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            load_q    <= load_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic: start on an aligned LW/SW entering X, finish on ack or timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_d    = load_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                // The timed-out instruction leaves X on the first idle edge.
                timeout_d = 1'b0;
                if (in_start) begin
                    state_d = StAccess;
                    cnt_d   = '0;
                end
            end
            StAccess: begin
                if (mem_ack) begin
                    state_d = StIdle;
                    if (x_op == OpLw) begin
                        load_d = mem_rdata;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d   = StIdle;
                    cnt_d     = cnt_q + 8'd1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory interface and forwarding outputs, all derived from registered state.
    always_comb begin
        mem_req        = stall;
        mem_we         = stall && (x_op == OpSw);
        mem_addr       = stall ? x_aluout : 16'h0000;
        mem_wdata      = stall ? x_bout : 16'h0000;
        new_mem_aluout = x_aluout;
        mem_rd         = x_rd;
        mem_regwrite   = x_regwrite && (x_op != OpSw);
        mem_pcwrite    = x_pcwrite;
    end

    // W next value: bubble while stalled, error bubble for misaligned/timed-out accesses.
    always_comb begin
        wb_data_d     = '0;
        wb_rd_d       = '0;
        wb_regwrite_d = 1'b0;
        mem_err_d     = 1'b0;
        err           = x_misaligned || timeout_q;
        if (!stall) begin
            wb_data_d     = (x_op == OpLw) ? load_q : x_aluout;
            wb_rd_d       = x_rd;
            wb_regwrite_d = x_regwrite && (x_op != OpSw) && !err;
            mem_err_d     = err;
        end
    end

    // W register updates on every edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_data     <= '0;
            wb_rd       <= '0;
            wb_regwrite <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            wb_data     <= wb_data_d;
            wb_rd       <= wb_rd_d;
            wb_regwrite <= wb_regwrite_d;
            mem_err     <= mem_err_d;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed testbench for memory_cycle.
module tb_memory_cycle;

    logic        clk;
    logic        rst;
    logic [15:0] aluout, bout, mem_addr, mem_wdata, mem_rdata, new_mem_aluout, wb_data;
    logic [3:0]  rd, op, mem_rd, wb_rd;
    logic        regwrite, pcwrite, flush, mem_req, mem_we, mem_ack, stall;
    logic        mem_regwrite, mem_pcwrite, wb_regwrite, mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] LW  = 4'b0100;
    localparam logic [3:0] SW  = 4'b0101;
    localparam logic [3:0] NOP = 4'b0000;
    localparam logic [3:0] ADD = 4'b0001;

    memory_cycle dut (
        .clk            (clk),
        .rst            (rst),
        .aluout         (aluout),
        .bout           (bout),
        .rd             (rd),
        .regwrite       (regwrite),
        .op             (op),
        .pcwrite        (pcwrite),
        .flush          (flush),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .stall          (stall),
        .new_mem_aluout (new_mem_aluout),
        .mem_rd         (mem_rd),
        .mem_regwrite   (mem_regwrite),
        .mem_pcwrite    (mem_pcwrite),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_regwrite    (wb_regwrite),
        .mem_err        (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] o, input logic [3:0] r, input logic w,
                          input logic [15:0] a, input logic [15:0] b);
        op = o; rd = r; regwrite = w; aluout = a; bout = b;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; pcwrite = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        set_in(ADD, 4'd1, 1'b1, 16'h7777, 16'h8888);
        #12;
        n_checks++;
        if ({mem_req, mem_we, stall, mem_regwrite, mem_pcwrite, wb_regwrite, mem_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {mem_req, mem_we, stall, mem_regwrite, mem_pcwrite, wb_regwrite, mem_err});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, new_mem_aluout, wb_data, mem_rd, wb_rd} !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0",
                     {mem_addr, mem_wdata, new_mem_aluout, wb_data, mem_rd, wb_rd});
        end
        set_in(NOP, 4'd0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        cycle();
    endtask

    task automatic test_alu();
        set_in(ADD, 4'd3, 1'b1, 16'h0042, 16'h0000);
        pcwrite = 1'b1;
        cycle();
        pcwrite = 1'b0;
        set_in(NOP, 4'd0, 1'b0, 16'h0000, 16'h0000);
        n_checks++;
        if ({new_mem_aluout, mem_rd, mem_regwrite, mem_pcwrite, stall} !== {16'h0042, 4'd3, 3'b110}) begin
            n_fail++;
            $display("FAIL alu_fwd: got %h/%0d/%b%b%b expected 0042/3/110",
                     new_mem_aluout, mem_rd, mem_regwrite, mem_pcwrite, stall);
        end
        cycle();
        n_checks++;
        if ({wb_data, wb_rd, wb_regwrite, mem_err, stall} !== {16'h0042, 4'd3, 3'b100}) begin
            n_fail++;
            $display("FAIL alu_wb: got %h/%0d/%b%b%b expected 0042/3/100",
                     wb_data, wb_rd, wb_regwrite, mem_err, stall);
        end
    endtask

    task automatic test_load();
        int stalls = 0;
        set_in(LW, 4'd5, 1'b1, 16'h0010, 16'h0000);
        cycle();
        set_in(NOP, 4'd0, 1'b0, 16'h0000, 16'h0000);
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_regwrite} !== {2'b10, 16'h0010, 1'b1}) begin
            n_fail++;
            $display("FAIL load_req: got req=%b we=%b addr=%h regw=%b expected 1/0/0010/1",
                     mem_req, mem_we, mem_addr, mem_regwrite);
        end
        for (int i = 1; i <= 3; i++) begin
            if (stall) stalls++;
            // Flush and new instruction while stalled must leave X untouched.
            if (i == 2) begin
                set_in(ADD, 4'd9, 1'b1, 16'h5555, 16'h0000);
                flush = 1'b1;
            end
            if (i == 3) begin
                mem_ack = 1'b1;
                mem_rdata = 16'hBEEF;
            end
            cycle();
            if (i == 2) begin
                n_checks++;
                if ({new_mem_aluout, mem_rd} !== {16'h0010, 4'd5}) begin
                    n_fail++;
                    $display("FAIL flush_in_stall: got %h/%0d expected 0010/5", new_mem_aluout, mem_rd);
                end
                set_in(NOP, 4'd0, 1'b0, 16'h0000, 16'h0000);
                flush = 1'b0;
            end
        end
        n_checks++;
        if (stalls !== 3) begin
            n_fail++;
            $display("FAIL load_stall_cycles: got %0d expected 3", stalls);
        end
        n_checks++;
        if ({stall, mem_req, wb_regwrite} !== 3'b000) begin
            n_fail++;
            $display("FAIL load_done: got stall=%b req=%b wbw=%b expected 000", stall, mem_req, wb_regwrite);
        end
        // Spurious ack in IDLE: must not overwrite load data or restart access.
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        cycle();
        mem_ack = 1'b0;
        n_checks++;
        if ({wb_data, wb_rd, wb_regwrite, mem_err, stall} !== {16'hBEEF, 4'd5, 3'b100}) begin
            n_fail++;
            $display("FAIL load_wb: got %h/%0d/%b%b%b expected BEEF/5/100",
                     wb_data, wb_rd, wb_regwrite, mem_err, stall);
        end
    endtask

    task automatic test_store();
        set_in(SW, 4'd7, 1'b1, 16'h0020, 16'h1234);
        cycle();
        set_in(NOP, 4'd0, 1'b0, 16'h0000, 16'h0000);
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_regwrite} !== {2'b11, 16'h0020, 16'h1234, 1'b0}) begin
            n_fail++;
            $display("FAIL store_req: got %b%b %h %h %b expected 11 0020 1234 0",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_regwrite);
        end
        mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
        n_checks++;
        if ({mem_req, mem_we, stall} !== 3'b000) begin
            n_fail++;
            $display("FAIL store_done: got %b%b%b expected 000", mem_req, mem_we, stall);
        end
        cycle();
        n_checks++;
        if ({wb_regwrite, mem_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL store_wb: got wbw=%b err=%b expected 00", wb_regwrite, mem_err);
        end
    endtask

    task automatic test_misaligned();
        set_in(LW, 4'd2, 1'b1, 16'h0011, 16'h0000);
        cycle();
        set_in(NOP, 4'd0, 1'b0, 16'h0000, 16'h0000);
        n_checks++;
        if ({mem_req, stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL misalign_req: got req=%b stall=%b expected 00", mem_req, stall);
        end
        cycle();
        n_checks++;
        if ({mem_err, wb_regwrite} !== 2'b10) begin
            n_fail++;
            $display("FAIL misalign_err: got err=%b wbw=%b expected 10", mem_err, wb_regwrite);
        end
        cycle();
        n_checks++;
        if (mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_err_pulse: got %b expected 0", mem_err);
        end
    endtask

    task automatic test_timeout();
        int stalls = 0;
        set_in(LW, 4'd4, 1'b1, 16'h0030, 16'h0000);
        cycle();
        set_in(NOP, 4'd0, 1'b0, 16'h0000, 16'h0000);
        while (stall === 1'b1 && stalls < 300) begin
            stalls++;
            cycle();
        end
        n_checks++;
        if (stalls !== 255) begin
            n_fail++;
            $display("FAIL timeout_stall_cycles: got %0d expected 255", stalls);
        end
        n_checks++;
        if (mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err_early: got %b expected 0", mem_err);
        end
        cycle();
        n_checks++;
        if ({mem_err, wb_regwrite} !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_err: got err=%b wbw=%b expected 10", mem_err, wb_regwrite);
        end
        cycle();
        n_checks++;
        if (mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err_pulse: got %b expected 0", mem_err);
        end
    endtask

    task automatic test_reset_mid_access();
        set_in(LW, 4'd6, 1'b1, 16'h0040, 16'h0000);
        cycle();
        set_in(NOP, 4'd0, 1'b0, 16'h0000, 16'h0000);
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got stall=%b expected 1", stall);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, stall, mem_regwrite} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid_async: got req=%b stall=%b mregw=%b expected 000",
                     mem_req, stall, mem_regwrite);
        end
        @(negedge clk);
        rst = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if ({wb_regwrite, mem_err, wb_rd, stall} !== 7'b0) begin
            n_fail++;
            $display("FAIL rst_mid_wb: got wbw=%b err=%b rd=%0d stall=%b expected 0/0/0/0",
                     wb_regwrite, mem_err, wb_rd, stall);
        end
    endtask

    task automatic test_back_to_back();
        set_in(ADD, 4'd10, 1'b1, 16'hA001, 16'h0000);
        cycle();
        set_in(ADD, 4'd11, 1'b1, 16'hA002, 16'h0000);
        cycle();
        n_checks++;
        if ({wb_data, wb_rd, wb_regwrite} !== {16'hA001, 4'd10, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_first: got %h/%0d/%b expected A001/10/1", wb_data, wb_rd, wb_regwrite);
        end
        // Flush with no stall turns the incoming ADD into a bubble.
        set_in(ADD, 4'd12, 1'b1, 16'hA003, 16'h0000);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        set_in(NOP, 4'd0, 1'b0, 16'h0000, 16'h0000);
        n_checks++;
        if ({wb_data, wb_rd, wb_regwrite} !== {16'hA002, 4'd11, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_second: got %h/%0d/%b expected A002/11/1", wb_data, wb_rd, wb_regwrite);
        end
        n_checks++;
        if ({mem_regwrite, mem_rd} !== 5'b0) begin
            n_fail++;
            $display("FAIL flush_bubble_x: got regw=%b rd=%0d expected 0/0", mem_regwrite, mem_rd);
        end
        cycle();
        n_checks++;
        if (wb_regwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_bubble_wb: got %b expected 0", wb_regwrite);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
